// File: rtl/systolic_result_drain_pkg.sv
// Shared definitions for the systolic array result path: matrix geometry,
// datapath widths and the drain controller state type.
package systolic_result_drain_pkg;

    localparam int MATRIX_A_ROW = 4;
    localparam int MATRIX_B_COL = 4;
    localparam int ACC_WIDTH    = 32;
    localparam int DATA_WIDTH   = 8;

    typedef enum logic [0:0] {
        IDLE  = 1'b0,
        DRAIN = 1'b1
    } drain_state_e;

    // Shift amounts at or beyond the accumulator width collapse to ACC_W-1.
    function automatic logic [4:0] clamp_shift(input logic [4:0] shift, input int acc_w);
        logic [4:0] res_s;
        if (int'({27'd0, shift}) >= acc_w) begin
            res_s = 5'(acc_w - 1);
        end else begin
            res_s = shift;
        end
        return res_s;
    endfunction

endpackage

// File: rtl/systolic_result_drain_requant_sat.sv
// Combinational requantiser: round-half-up right shift, optional ReLU and
// saturation of a signed accumulator down to the output element width.
module requant_sat #(
    parameter int ACC_W = 32,
    parameter int OUT_W = 8
) (
    input  logic [ACC_W-1:0] acc_i,
    input  logic [4:0]       shift_i,
    input  logic             relu_en_i,
    output logic [OUT_W-1:0] data_o
);

    localparam logic signed [ACC_W:0] SAT_MAX = {{(ACC_W-OUT_W+2){1'b0}}, {(OUT_W-1){1'b1}}};
    localparam logic signed [ACC_W:0] SAT_MIN = {{(ACC_W-OUT_W+2){1'b1}}, {(OUT_W-1){1'b0}}};

    logic signed [ACC_W:0] ext_s;
    logic signed [ACC_W:0] rnd_s;
    logic signed [ACC_W:0] val_s;

    // One extra bit keeps the rounding add from overflowing at the positive limit.
    always_comb begin
        ext_s = $signed({acc_i[ACC_W-1], acc_i});
        rnd_s = '0;
        val_s = ext_s;
        if (shift_i != 5'd0) begin
            rnd_s = {{ACC_W{1'b0}}, 1'b1} << (shift_i - 5'd1);
            val_s = (ext_s + rnd_s) >>> shift_i;
        end else begin
            val_s = ext_s;
        end
        if (relu_en_i && val_s[ACC_W]) begin
            val_s = '0;
        end else begin
            val_s = val_s;
        end
        if (val_s > SAT_MAX) begin
            data_o = SAT_MAX[OUT_W-1:0];
        end else if (val_s < SAT_MIN) begin
            data_o = SAT_MIN[OUT_W-1:0];
        end else begin
            data_o = val_s[OUT_W-1:0];
        end
    end

endmodule

// File: rtl/systolic_result_drain.sv
// Snapshots the PE accumulator matrix on start and streams it out row-major
// through a valid/ready port, requantising each element on the way.
module systolic_result_drain
    import systolic_result_drain_pkg::*;
#(
    parameter int ROWS  = MATRIX_A_ROW,
    parameter int COLS  = MATRIX_B_COL,
    parameter int ACC_W = ACC_WIDTH,
    parameter int OUT_W = DATA_WIDTH,
    localparam int RW   = (ROWS > 1) ? $clog2(ROWS) : 1,
    localparam int CW   = (COLS > 1) ? $clog2(COLS) : 1
) (
    input  logic                                  clk_i,
    input  logic                                  rst_async_n_i,
    input  logic                                  start_i,
    input  logic [4:0]                            shift_i,
    input  logic                                  relu_en_i,
    input  logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  result_i,
    output logic                                  busy_o,
    output logic                                  acc_clear_o,
    output logic                                  out_valid_o,
    input  logic                                  out_ready_i,
    output logic [OUT_W-1:0]                      out_data_o,
    output logic [RW-1:0]                         out_row_o,
    output logic [CW-1:0]                         out_col_o,
    output logic                                  out_last_o,
    output logic                                  done_o
);

    drain_state_e                          state_q, state_d;
    logic [ROWS-1:0][COLS-1:0][ACC_W-1:0]  snap_q, snap_d;
    logic [4:0]                            shift_q, shift_d;
    logic                                  relu_q, relu_d;
    logic                                  busy_q, busy_d, clear_q, clear_d;
    logic                                  valid_q, valid_d, last_q, last_d, done_q, done_d;
    logic [OUT_W-1:0]                      data_q, data_d;
    logic [RW-1:0]                         row_q, row_d, nrow_s;
    logic [CW-1:0]                         col_q, col_d, ncol_s;
    logic [ACC_W-1:0]                      rq_acc_s;
    logic [4:0]                            rq_shift_s;
    logic                                  rq_relu_s;
    logic [OUT_W-1:0]                      rq_data_s;
    logic                                  hs_s;

    requant_sat #(.ACC_W(ACC_W), .OUT_W(OUT_W)) u_requant (
        .acc_i     (rq_acc_s),
        .shift_i   (rq_shift_s),
        .relu_en_i (rq_relu_s),
        .data_o    (rq_data_s)
    );

    // Next-state logic; the requantiser sees the live inputs only at start, the snapshot afterwards.
    always_comb begin
        state_d    = state_q;
        snap_d     = snap_q;
        shift_d    = shift_q;
        relu_d     = relu_q;
        busy_d     = busy_q;
        clear_d    = 1'b0;
        valid_d    = valid_q;
        data_d     = data_q;
        row_d      = row_q;
        col_d      = col_q;
        last_d     = last_q;
        done_d     = 1'b0;
        hs_s       = valid_q && out_ready_i;
        rq_acc_s   = result_i[0][0];
        rq_shift_s = clamp_shift(shift_i, ACC_W);
        rq_relu_s  = relu_en_i;
        if (col_q == CW'(COLS - 1)) begin
            ncol_s = '0;
            nrow_s = (row_q == RW'(ROWS - 1)) ? '0 : row_q + RW'(1);
        end else begin
            ncol_s = col_q + CW'(1);
            nrow_s = row_q;
        end
        case (state_q)
            IDLE: begin
                if (start_i) begin
                    state_d = DRAIN;
                    snap_d  = result_i;
                    shift_d = clamp_shift(shift_i, ACC_W);
                    relu_d  = relu_en_i;
                    busy_d  = 1'b1;
                    clear_d = 1'b1;
                    valid_d = 1'b1;
                    data_d  = rq_data_s;
                    row_d   = '0;
                    col_d   = '0;
                    last_d  = (ROWS == 1) && (COLS == 1);
                end else begin
                    state_d = IDLE;
                end
            end
            DRAIN: begin
                rq_acc_s   = snap_q[nrow_s][ncol_s];
                rq_shift_s = shift_q;
                rq_relu_s  = relu_q;
                if (hs_s && last_q) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                    valid_d = 1'b0;
                    last_d  = 1'b0;
                    done_d  = 1'b1;
                end else if (hs_s) begin
                    row_d  = nrow_s;
                    col_d  = ncol_s;
                    data_d = rq_data_s;
                    last_d = (nrow_s == RW'(ROWS - 1)) && (ncol_s == CW'(COLS - 1));
                end else begin
                    state_d = DRAIN;
                end
            end
            default: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                valid_d = 1'b0;
                last_d  = 1'b0;
            end
        endcase
    end

    // Control and output registers; reset aborts any drain in flight.
    always_ff @(posedge clk_i or negedge rst_async_n_i) begin
        if (!rst_async_n_i) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
            clear_q <= 1'b0;
            valid_q <= 1'b0;
            data_q  <= '0;
            row_q   <= '0;
            col_q   <= '0;
            last_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            busy_q  <= busy_d;
            clear_q <= clear_d;
            valid_q <= valid_d;
            data_q  <= data_d;
            row_q   <= row_d;
            col_q   <= col_d;
            last_q  <= last_d;
            done_q  <= done_d;
        end
    end

    // Snapshot holds data only, so it carries no reset.
    always_ff @(posedge clk_i) begin
        snap_q  <= snap_d;
        shift_q <= shift_d;
        relu_q  <= relu_d;
    end

    assign busy_o      = busy_q;
    assign acc_clear_o = clear_q;
    assign out_valid_o = valid_q;
    assign out_data_o  = data_q;
    assign out_row_o   = row_q;
    assign out_col_o   = col_q;
    assign out_last_o  = last_q;
    assign done_o      = done_q;

endmodule

// File: doc/systolic_result_drain.md
SYSTOLIC_RESULT_DRAIN -- requirements
Module: systolic_result_drain

Interface
REQ-001 SHALL have parameter ROWS, default MATRIX_A_ROW: PE rows in the result matrix.
REQ-002 SHALL have parameter COLS, default MATRIX_B_COL: PE columns in the result matrix.
REQ-003 SHALL have parameter ACC_W, default ACC_WIDTH: signed accumulator width.
REQ-004 SHALL have parameter OUT_W, default DATA_WIDTH: signed output element width.
REQ-005 SHALL have port clk_i  input  1  single clock; all logic on rising edge.
REQ-006 SHALL have port rst_async_n_i  input  1  asynchronous, active-low reset.
REQ-007 SHALL have port start_i  input  1  pulse: snapshot result_i and begin draining.
REQ-008 SHALL have port shift_i  input  5  right-shift amount for requantisation.
REQ-009 SHALL have port relu_en_i  input  1  clamp negative results to zero.
REQ-010 SHALL have port result_i  input  [ROWS][COLS]xACC_W  array accumulators, two's complement.
REQ-011 SHALL have port busy_o  output  1  high while a drain is in progress.
REQ-012 SHALL have port acc_clear_o  output  1  one-cycle pulse telling the array to clear its accumulators.
REQ-013 SHALL have port out_valid_o / out_ready_i  output / input  1 / 1  output stream handshake.
REQ-014 SHALL have port out_data_o  output  OUT_W  requantised element.
REQ-015 SHALL have ports out_row_o / out_col_o  output  $clog2(ROWS) / $clog2(COLS), minimum 1 bit each  element coordinates.
REQ-016 SHALL have port out_last_o  output  1  high on the final element of the drain.
REQ-017 SHALL have port done_o  output  1  one-cycle pulse after the last handshake.

Function
REQ-018 SHALL implement FSM IDLE -> DRAIN on start_i in IDLE, and DRAIN -> IDLE on the handshake where out_last_o=1.
REQ-019 SHALL, on start_i in IDLE at edge k, register all of result_i, shift_i and relu_en_i; changes to these inputs after edge k SHALL have no effect.
REQ-020 SHALL ignore start_i while in DRAIN.
REQ-021 SHALL assert busy_o and acc_clear_o (single cycle) and out_valid_o from cycle k+1.
REQ-022 SHALL emit elements in row-major order, (0,0),(0,1)...(ROWS-1,COLS-1), with coordinates on out_row_o/out_col_o.
REQ-023 SHALL transfer an element only when out_valid_o && out_ready_i, sustaining one element per cycle.
REQ-024 SHALL hold out_data_o, coordinates and out_last_o stable while out_valid_o && !out_ready_i.
REQ-025 SHALL, on the last handshake, deassert out_valid_o and busy_o in the next cycle, and pulse done_o in that same cycle.
REQ-026 SHALL accept a new start_i in the cycle done_o is high.
REQ-027 SHALL clamp shift_i values >= ACC_W to ACC_W-1.
REQ-028 SHALL compute each element in ACC_W+1-bit signed arithmetic as follows:
- s=0: value = acc.
- s>0: value = (acc + 2^(s-1)) >>> s (round half up).
REQ-029 SHALL, when relu_en is set, replace negative values with 0.
REQ-030 SHALL saturate the value to [-2^(OUT_W-1), 2^(OUT_W-1)-1].
REQ-031 SHALL register out_data_o, with no combinational path from result_i to any output.

Reset
REQ-032 SHALL, on reset assertion, asynchronously set the FSM to IDLE and drive every output to 0: busy_o, acc_clear_o, out_valid_o, out_data_o, out_row_o, out_col_o, out_last_o, done_o.
REQ-033 SHALL abort a drain on reset mid-operation, with no done_o and no further elements after release.
REQ-034 SHALL leave the snapshot registers unreset (data-only).

Structure
REQ-035 SHALL take MATRIX_A_ROW, MATRIX_B_COL, ACC_WIDTH and DATA_WIDTH from the shared definitions package, and SHALL add drain_state_e (IDLE, DRAIN) there.
REQ-036 SHALL place the requantisation datapath (round, shift, ReLU, saturate) in the sub-module requant_sat (combinational) so it can be reused by other output paths.
REQ-037 SHALL target 120-400 lines of RTL.

Verification
REQ-038 SHALL verify: result[0][0]=-26, shift 0, relu off -> first element data 0xE6 (-26) at (0,0); acc_clear_o pulses at cycle k+1.
REQ-039 SHALL verify: acc=-26 with shift 2 -> -6; acc=1000 with shift 3 -> 125; acc=-26 with shift 0 and relu on -> 0.
REQ-040 SHALL verify saturation: acc=300 -> 127; acc=-300 -> -128; acc=0x7FFFFFFF with shift 31 -> 1 (ACC_W=32).
REQ-041 SHALL verify: out_ready_i toggled randomly during a full drain -> all ROWS*COLS elements delivered once, in order, stable while stalled, out_last_o only on (ROWS-1,COLS-1), and done_o one cycle after the last handshake.
REQ-042 SHALL verify: start_i re-pulsed mid-drain with different result_i -> ignored, and the original snapshot completes unchanged.
REQ-043 SHALL verify: reset asserted after 3 handshakes -> all outputs 0 immediately, no done_o; a fresh start_i then drains from (0,0).
